if_fetch_unit: RTL

//  Instruction-fetch stage of the 5-stage RISC-V core; feeds IF/ID pipeline register (inst, pc).

---
 rtl/if_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests to instruction memory,
// buffers responses in a small FIFO for IF/ID and flushes in-flight work on branch/jump redirects.
module if_fetch_unit #(
  parameter int                 DWIDTH     = 32,
  parameter logic [DWIDTH-1:0]  RESET_PC   = '0,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DWIDTH-1:0] inst,
  output logic [DWIDTH-1:0] inst_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_pc
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DWIDTH-1:0] fetch_pc;
  logic [DWIDTH-1:0] resp_pc;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     kill_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DWIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic [DWIDTH-1:0] pc_mem   [FIFO_DEPTH];

  logic [CW:0]       in_flight;
  logic              handshake;
  logic              rsp;
  logic              push;
  logic              pop;
  logic [CW-1:0]     outstanding_next;
  logic [DWIDTH-1:0] target_pc;

  // Buffered entries plus outstanding requests never exceed the FIFO, so a response always has room.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req  = rst_n & ~redirect_valid & (in_flight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign handshake = imem_req & imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign rsp  = imem_rvalid & (outstanding != '0);
  assign push = rsp & ~redirect_valid & (kill_cnt == '0);
  assign pop  = inst_valid & id_ready & ~redirect_valid;

  assign outstanding_next = outstanding + CW'(handshake) - CW'(rsp);
  assign target_pc        = redirect_pc & ~DWIDTH'(3);

  assign inst_valid = (fifo_count != '0);
  assign inst       = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

  // On redirect every response still owed by memory belongs to the abandoned path and is killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      fifo_count  <= '0;
      outstanding <= '0;
      kill_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc   <= target_pc;
        resp_pc    <= target_pc;
        kill_cnt   <= outstanding_next;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (handshake) begin
          fetch_pc <= fetch_pc + DWIDTH'(4);
        end
        if (rsp && (kill_cnt != '0)) begin
          kill_cnt <= kill_cnt - CW'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + DWIDTH'(4);
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible while fifo_count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule
